control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Timing-and-control unit directly upstream of the datapath.
- Holds a sequence counter (T0..T6), the indirect bit I and the run/halt flag.
- Drives BUS_SEL, CTRL_SGNLS and ALU_OPSEL to execute fetch, decode and execute of the basic-computer instruction set.
- Consumes IR, AC, DR and E fed back from the datapath.

Parameters:
WIDTH, 16, data word width of IR/AC/DR
CTRL_LNGTH, 20, width of CTRL_SGNLS; must match the datapath
SC_W, 3, sequence-counter width (T0..T6 used)

Ports:
clk  in  1  rising-edge clock
RST_N  in  1  asynchronous active-low reset
START  in  1  single-cycle pulse; restarts execution from a halted state
IR  in  WIDTH  instruction register from the datapath
AC  in  WIDTH  accumulator from the datapath
DR  in  WIDTH  data register from the datapath
E  in  1  E flip-flop from the datapath
BUS_SEL  out  3  bus source: 0 AR, 1 PC, 2 DR, 3 AC, 4 IR, 5 TR, 6 MEM, 7 WRD
CTRL_SGNLS  out  CTRL_LNGTH  bit 0 LD_AR, 1 INR_AR, 2 CLR_AR, 3 LD_PC, 4 INR_PC, 5 CLR_PC, 6 LD_DR, 7 INR_DR, 8 CLR_DR, 9 LD_AC, 10 INR_AC, 11 CLR_AC, 12 LD_IR, 13 LD_TR, 14 INR_TR, 15 CLR_TR, 16 MEM_WE, 17 CLR_E, 18 CMP_E, 19 tied 0
ALU_OPSEL  out  3  0 AND, 1 ADD, 2 pass DR, 3 complement AC, 4 CIR, 5 CIL
SC_OUT  out  SC_W  current timing state
HALTED  out  1  high when the run flag is clear

Behaviour:
Registered state: SC, I, S (run flag). All outputs are combinational from SC, I, S, IR, AC, DR and E.
- When S=0 or RST_N=0, every control output is 0; BUS_SEL is 0 and ALU_OPSEL is 0.
- A signal asserted during Tn takes effect at the clock edge ending Tn.
- Reset (async): SC=0, I=0, S=1. Execution begins at T0 on the first edge after release.

Fetch/decode sequence (D = IR[14:12], decoded D0..D7):
- T0: BUS_SEL=1, LD_AR.
- T1: BUS_SEL=6, LD_IR, INR_PC.
- T2: BUS_SEL=4, LD_AR; I <= IR[15] at the edge.
- T3, D7=0 and I=1: BUS_SEL=6, LD_AR.
- T3, D7=0 and I=0: no operation.
- T3, D7=1 and I=0: register-reference instruction, then SC <= 0.
- T3, D7=1 and I=1: I/O opcode, no operation, SC <= 0.

Memory reference (SC <= 0 at the final step):
- AND: T4 BUS_SEL=6, LD_DR; T5 ALU_OPSEL=0, LD_AC.
- ADD: T4 BUS_SEL=6, LD_DR; T5 ALU_OPSEL=1, LD_AC.
- LDA: T4 BUS_SEL=6, LD_DR; T5 ALU_OPSEL=2, LD_AC.
- STA: T4 BUS_SEL=3, MEM_WE.
- BUN: T4 BUS_SEL=0, LD_PC.
- BSA: T4 BUS_SEL=1, MEM_WE, INR_AR; T5 BUS_SEL=0, LD_PC.
- ISZ: T4 BUS_SEL=6, LD_DR; T5 INR_DR; T6 BUS_SEL=2, MEM_WE, and INR_PC if DR==0. DR wraps 0xFFFF to 0x0000, which causes the skip.

Register reference at T3 (one IR bit per operation):
- AC operations, at most one applied, priority order: CLA(11) CLR_AC; CMA(9) op 3 + LD_AC; CIR(7) op 4 + LD_AC; CIL(6) op 5 + LD_AC; INC(5) INR_AC.
- E operations: CLE(10) CLR_E and CME(8) CMP_E are independent of the AC operations. If both are set, CLE wins.
- Skips: SPA(4) if AC[15]=0; SNA(3) if AC[15]=1; SZA(2) if AC==0; SZE(1) if E==0. Any satisfied skip gives a single INR_PC.
- HLT(0): S <= 0 at the edge; SC <= 0.
- IR[11:0]==0: no operation.

Sequence counter and run flag:
- SC increments every edge while S=1 unless cleared as above.
- While S=0, SC is held at 0 and START is sampled.
- START=1 while S=0 sets S=1; T0 runs on the next cycle.
- START while S=1 is ignored.

Optional Feature:
Macro CTRL_SEQ_ICOUNT_EN.
- Defined: adds output ICOUNT[15:0], reset 0. It increments on every edge where SC is cleared by instruction completion (including HLT and I/O no-ops) and wraps at 0xFFFF to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Assert RST_N=0 mid-T4 of an STA: MEM_WE drops to 0 immediately. After release: SC_OUT=0, HALTED=0, and T0 asserts LD_AR with BUS_SEL=1.
2. LDA indirect, IR=0xA010 (I=1, D2): T3 asserts LD_AR with BUS_SEL=6; T5 asserts ALU_OPSEL=2 with LD_AC; SC_OUT returns to 0 after T5.
3. ISZ with DR=0xFFFF at T4: T5 asserts INR_DR. Drive DR=0x0000 at T6: INR_PC and MEM_WE are asserted with BUS_SEL=2. Drive DR=0x0001: no INR_PC.
4. Register reference IR=0x7224 (CMA+INC+SZA) with AC=0: only ALU_OPSEL=3 with LD_AC is asserted (INR_AC suppressed), plus INR_PC; SC=0 next cycle.
5. Issue HLT (IR=0x7001): HALTED=1 and outputs stay 0 for 10 cycles. Pulse START: T0 fetch resumes the next cycle. With CTRL_SEQ_ICOUNT_EN, ICOUNT advances by 1 for the HLT.
6. BSA (IR=0x5123): T4 asserts BUS_SEL=1, MEM_WE and INR_AR; T5 asserts BUS_SEL=0 and LD_PC; no LD_AC is asserted at any point.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: timing-and-control unit driving the basic-computer datapath.
// Optional instruction-completion counter on ICOUNT, enabled by defining CTRL_SEQ_ICOUNT_EN.

module control_sequencer #(
  parameter int WIDTH      = 16,
  parameter int CTRL_LNGTH = 20,
  parameter int SC_W       = 3
) (
  input  logic                  clk,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [WIDTH-1:0]      IR,
  input  logic [WIDTH-1:0]      AC,
  input  logic [WIDTH-1:0]      DR,
  input  logic                  E,
  output logic [2:0]            BUS_SEL,
  output logic [CTRL_LNGTH-1:0] CTRL_SGNLS,
  output logic [2:0]            ALU_OPSEL,
  output logic [SC_W-1:0]       SC_OUT,
`ifdef CTRL_SEQ_ICOUNT_EN
  output logic [15:0]           ICOUNT,
`endif
  output logic                  HALTED
);

  localparam logic [SC_W-1:0] T0 = SC_W'(0);
  localparam logic [SC_W-1:0] T1 = SC_W'(1);
  localparam logic [SC_W-1:0] T2 = SC_W'(2);
  localparam logic [SC_W-1:0] T3 = SC_W'(3);
  localparam logic [SC_W-1:0] T4 = SC_W'(4);
  localparam logic [SC_W-1:0] T5 = SC_W'(5);
  localparam logic [SC_W-1:0] T6 = SC_W'(6);

  localparam logic [2:0] BUS_AR  = 3'd0;
  localparam logic [2:0] BUS_PC  = 3'd1;
  localparam logic [2:0] BUS_DR  = 3'd2;
  localparam logic [2:0] BUS_AC  = 3'd3;
  localparam logic [2:0] BUS_IR  = 3'd4;
  localparam logic [2:0] BUS_MEM = 3'd6;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_DR  = 3'd2;
  localparam logic [2:0] ALU_CMA = 3'd3;
  localparam logic [2:0] ALU_CIR = 3'd4;
  localparam logic [2:0] ALU_CIL = 3'd5;

  localparam logic [2:0] D_AND = 3'd0;
  localparam logic [2:0] D_ADD = 3'd1;
  localparam logic [2:0] D_LDA = 3'd2;
  localparam logic [2:0] D_STA = 3'd3;
  localparam logic [2:0] D_BUN = 3'd4;
  localparam logic [2:0] D_BSA = 3'd5;
  localparam logic [2:0] D_ISZ = 3'd6;
  localparam logic [2:0] D_REG = 3'd7;

  localparam int LD_AR  = 0;
  localparam int INR_AR = 1;
  localparam int LD_PC  = 3;
  localparam int INR_PC = 4;
  localparam int LD_DR  = 6;
  localparam int INR_DR = 7;
  localparam int LD_AC  = 9;
  localparam int INR_AC = 10;
  localparam int CLR_AC = 11;
  localparam int LD_IR  = 12;
  localparam int MEM_WE = 16;
  localparam int CLR_E  = 17;
  localparam int CMP_E  = 18;

  logic [SC_W-1:0]       sc;
  logic                  ind;
  logic                  run;
  logic [2:0]            d;
  logic [2:0]            bus_sel;
  logic [2:0]            alu_op;
  logic [CTRL_LNGTH-1:0] ctrl;
  logic                  sc_clr;
  logic                  halt;
  logic                  skip;

  assign d = IR[WIDTH-2 -: 3];

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    bus_sel = BUS_AR;
    alu_op  = ALU_AND;
    ctrl    = '0;
    sc_clr  = 1'b0;
    halt    = 1'b0;
    skip    = 1'b0;
    if (run) begin
      case (sc)
        T0: begin
          bus_sel     = BUS_PC;
          ctrl[LD_AR] = 1'b1;
        end
        T1: begin
          bus_sel      = BUS_MEM;
          ctrl[LD_IR]  = 1'b1;
          ctrl[INR_PC] = 1'b1;
        end
        T2: begin
          bus_sel     = BUS_IR;
          ctrl[LD_AR] = 1'b1;
        end
        T3: begin
          if (d != D_REG) begin
            if (ind) begin
              bus_sel     = BUS_MEM;
              ctrl[LD_AR] = 1'b1;
            end
          end else begin
            sc_clr = 1'b1;
            // I=1 with D7 is an I/O opcode, executed here as a no-op.
            if (!ind) begin
              if (IR[11]) begin
                ctrl[CLR_AC] = 1'b1;
              end else if (IR[9]) begin
                alu_op      = ALU_CMA;
                ctrl[LD_AC] = 1'b1;
              end else if (IR[7]) begin
                alu_op      = ALU_CIR;
                ctrl[LD_AC] = 1'b1;
              end else if (IR[6]) begin
                alu_op      = ALU_CIL;
                ctrl[LD_AC] = 1'b1;
              end else if (IR[5]) begin
                ctrl[INR_AC] = 1'b1;
              end
              if (IR[10])     ctrl[CLR_E] = 1'b1;
              else if (IR[8]) ctrl[CMP_E] = 1'b1;
              skip = (IR[4] && !AC[WIDTH-1]) || (IR[3] && AC[WIDTH-1]) ||
                     (IR[2] && (AC == '0)) || (IR[1] && !E);
              ctrl[INR_PC] = skip;
              halt         = IR[0];
            end
          end
        end
        T4: begin
          case (d)
            D_AND, D_ADD, D_LDA, D_ISZ: begin
              bus_sel     = BUS_MEM;
              ctrl[LD_DR] = 1'b1;
            end
            D_STA: begin
              bus_sel      = BUS_AC;
              ctrl[MEM_WE] = 1'b1;
              sc_clr       = 1'b1;
            end
            D_BUN: begin
              bus_sel     = BUS_AR;
              ctrl[LD_PC] = 1'b1;
              sc_clr      = 1'b1;
            end
            D_BSA: begin
              bus_sel      = BUS_PC;
              ctrl[MEM_WE] = 1'b1;
              ctrl[INR_AR] = 1'b1;
            end
            default: sc_clr = 1'b1;
          endcase
        end
        T5: begin
          case (d)
            D_AND: begin
              alu_op      = ALU_AND;
              ctrl[LD_AC] = 1'b1;
              sc_clr      = 1'b1;
            end
            D_ADD: begin
              alu_op      = ALU_ADD;
              ctrl[LD_AC] = 1'b1;
              sc_clr      = 1'b1;
            end
            D_LDA: begin
              alu_op      = ALU_DR;
              ctrl[LD_AC] = 1'b1;
              sc_clr      = 1'b1;
            end
            D_BSA: begin
              bus_sel     = BUS_AR;
              ctrl[LD_PC] = 1'b1;
              sc_clr      = 1'b1;
            end
            D_ISZ:   ctrl[INR_DR] = 1'b1;
            default: sc_clr = 1'b1;
          endcase
        end
        T6: begin
          sc_clr = 1'b1;
          if (d == D_ISZ) begin
            // DR has already been incremented; a wrap to zero means skip.
            bus_sel      = BUS_DR;
            ctrl[MEM_WE] = 1'b1;
            ctrl[INR_PC] = (DR == '0);
          end
        end
        default: sc_clr = 1'b1;
      endcase
    end
  end

  // Reset forces the control outputs quiet immediately, not at the next edge.
  assign BUS_SEL    = RST_N ? bus_sel : 3'd0;
  assign ALU_OPSEL  = RST_N ? alu_op  : 3'd0;
  assign CTRL_SGNLS = RST_N ? ctrl    : '0;
  assign SC_OUT     = sc;
  assign HALTED     = ~run;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      sc  <= T0;
      ind <= 1'b0;
      run <= 1'b1;
    end else if (run) begin
      if (sc == T2) ind <= IR[WIDTH-1];
      sc <= sc_clr ? T0 : sc + 1'b1;
      if (halt) run <= 1'b0;
    end else begin
      sc <= T0;
      if (START) run <= 1'b1;
    end
  end

`ifdef CTRL_SEQ_ICOUNT_EN
  logic [15:0] icount;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N)              icount <= 16'd0;
    else if (run && sc_clr)  icount <= icount + 16'd1;
  end

  assign ICOUNT = icount;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed literal checks plus
// randomized instruction streams compared against a register-transfer table model.

module tb_control_sequencer;

  localparam int C_LD_AR  = 0;
  localparam int C_INR_AR = 1;
  localparam int C_LD_PC  = 3;
  localparam int C_INR_PC = 4;
  localparam int C_LD_DR  = 6;
  localparam int C_INR_DR = 7;
  localparam int C_LD_AC  = 9;
  localparam int C_INR_AC = 10;
  localparam int C_CLR_AC = 11;
  localparam int C_LD_IR  = 12;
  localparam int C_MEM_WE = 16;
  localparam int C_CLR_E  = 17;
  localparam int C_CMP_E  = 18;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] ir, ac, dr;
  logic        e;
  logic [2:0]  bus_sel, alu_opsel, sc_out;
  logic [19:0] ctrl;
  logic        halted;
`ifdef CTRL_SEQ_ICOUNT_EN
  logic [15:0] icount;
`endif

  control_sequencer dut (
    .clk        (clk),
    .RST_N      (rst_n),
    .START      (start),
    .IR         (ir),
    .AC         (ac),
    .DR         (dr),
    .E          (e),
    .BUS_SEL    (bus_sel),
    .CTRL_SGNLS (ctrl),
    .ALU_OPSEL  (alu_opsel),
    .SC_OUT     (sc_out),
`ifdef CTRL_SEQ_ICOUNT_EN
    .ICOUNT     (icount),
`endif
    .HALTED     (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  bus;
    logic [2:0]  op;
    logic [19:0] ctrl;
    logic [2:0]  sc;
    logic        halted;
  } obs_t;

  int   n_pass  = 0;
  int   n_total = 0;
  obs_t exp_obs;
  logic exp_valid = 1'b0;
  int   exp_icount = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, expv, $time);
  endtask

  // Register transfers of one instruction at timing step t, straight from the ISA table.
  function automatic obs_t micro(input int t, input logic [15:0] i_r, input logic [15:0] a,
                                 input logic [15:0] d_r, input logic ee);
    obs_t       o;
    logic [2:0] opc;
    o   = '0;
    o.sc = 3'(t);
    opc = i_r[14:12];
    case (t)
      0: begin o.bus = 3'd1; o.ctrl[C_LD_AR] = 1'b1; end
      1: begin o.bus = 3'd6; o.ctrl[C_LD_IR] = 1'b1; o.ctrl[C_INR_PC] = 1'b1; end
      2: begin o.bus = 3'd4; o.ctrl[C_LD_AR] = 1'b1; end
      3: begin
        if (opc != 3'd7) begin
          if (i_r[15]) begin o.bus = 3'd6; o.ctrl[C_LD_AR] = 1'b1; end
        end else if (!i_r[15]) begin
          if (i_r[11])     o.ctrl[C_CLR_AC] = 1'b1;
          else if (i_r[9]) begin o.op = 3'd3; o.ctrl[C_LD_AC] = 1'b1; end
          else if (i_r[7]) begin o.op = 3'd4; o.ctrl[C_LD_AC] = 1'b1; end
          else if (i_r[6]) begin o.op = 3'd5; o.ctrl[C_LD_AC] = 1'b1; end
          else if (i_r[5]) o.ctrl[C_INR_AC] = 1'b1;
          if (i_r[10])     o.ctrl[C_CLR_E] = 1'b1;
          else if (i_r[8]) o.ctrl[C_CMP_E] = 1'b1;
          o.ctrl[C_INR_PC] = (i_r[4] && !a[15]) || (i_r[3] && a[15]) ||
                             (i_r[2] && a == 16'h0) || (i_r[1] && !ee);
        end
      end
      default: begin
        case (opc)
          3'd0, 3'd1, 3'd2: begin
            // AND/ADD/LDA use their own opcode number as the ALU select.
            if (t == 4) begin o.bus = 3'd6; o.ctrl[C_LD_DR] = 1'b1; end
            else begin o.op = opc; o.ctrl[C_LD_AC] = 1'b1; end
          end
          3'd3: begin o.bus = 3'd3; o.ctrl[C_MEM_WE] = 1'b1; end
          3'd4: begin o.bus = 3'd0; o.ctrl[C_LD_PC] = 1'b1; end
          3'd5: begin
            if (t == 4) begin o.bus = 3'd1; o.ctrl[C_MEM_WE] = 1'b1; o.ctrl[C_INR_AR] = 1'b1; end
            else begin o.bus = 3'd0; o.ctrl[C_LD_PC] = 1'b1; end
          end
          3'd6: begin
            if (t == 4)      begin o.bus = 3'd6; o.ctrl[C_LD_DR] = 1'b1; end
            else if (t == 5) o.ctrl[C_INR_DR] = 1'b1;
            else begin
              o.bus = 3'd2; o.ctrl[C_MEM_WE] = 1'b1; o.ctrl[C_INR_PC] = (d_r == 16'h0);
            end
          end
          default: ;
        endcase
      end
    endcase
    return o;
  endfunction

  function automatic int instr_len(input logic [15:0] i_r);
    case (i_r[14:12])
      3'd7:       return 4;
      3'd3, 3'd4: return 5;
      3'd6:       return 7;
      default:    return 6;
    endcase
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom % 4)
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000 | 16'($urandom);
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] gen_ir();
    logic [2:0]  opc;
    logic        ib;
    logic [11:0] lo;
    opc = 3'($urandom % 8);
    ib  = 1'($urandom % 2);
    lo  = 12'($urandom & $urandom);
    if (opc == 3'd7 && !ib) lo[0] = ($urandom % 8 == 0);
    return {ib, opc, lo};
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      check("cycle", {bus_sel, alu_opsel, ctrl, sc_out, halted}, exp_obs);
`ifdef CTRL_SEQ_ICOUNT_EN
      check("icount", icount, 16'(exp_icount));
`endif
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after an edge with the DUT sitting in T0.
  task automatic do_reset();
    exp_valid = 1'b0;
    start = 1'b0;
    ir = 16'h0; ac = 16'h0; dr = 16'h0; e = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] iv;
  int          len;
  int          k;

  initial begin
    // Reset in the middle of STA T4.
    do_reset();
    ir = 16'h3000;
    repeat (4) adv();
    #2 check("sta_t4", {bus_sel, ctrl}, {3'd3, 20'h10000});
    rst_n = 1'b0;
    #1 check("rst_quiet", {bus_sel, alu_opsel, ctrl}, 26'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("rst_release", {sc_out, halted, bus_sel, ctrl}, {3'd0, 1'b0, 3'd1, 20'h00001});

    // LDA indirect.
    do_reset();
    ir = 16'hA010;
    repeat (3) adv();
    #2 check("lda_t3", {bus_sel, ctrl}, {3'd6, 20'h00001});
    adv();
    #2 check("lda_t4", {bus_sel, ctrl}, {3'd6, 20'h00040});
    adv();
    #2 check("lda_t5", {alu_opsel, ctrl, sc_out}, {3'd2, 20'h00200, 3'd5});
    adv();
    #2 check("lda_done", {sc_out, ctrl}, {3'd0, 20'h00001});

    // ISZ wrap and no-wrap.
    do_reset();
    ir = 16'h6050;
    repeat (4) adv();
    dr = 16'hFFFF;
    #2 check("isz_t4", {bus_sel, ctrl}, {3'd6, 20'h00040});
    adv();
    #2 check("isz_t5", ctrl, 20'h00080);
    adv();
    dr = 16'h0000;
    #2 check("isz_t6_skip", {bus_sel, ctrl}, {3'd2, 20'h10010});
    dr = 16'h0001;
    #2 check("isz_t6_noskip", {bus_sel, ctrl}, {3'd2, 20'h10000});
    adv();
    #2 check("isz_done", sc_out, 3'd0);

    // CMA+INC+SZA with AC=0.
    do_reset();
    ir = 16'h7224; ac = 16'h0000;
    repeat (3) adv();
    #2 check("rr_t3", {alu_opsel, ctrl}, {3'd3, 20'h00210});
    adv();
    #2 check("rr_done", sc_out, 3'd0);

    // HLT then restart.
    do_reset();
    ir = 16'h7001; ac = 16'h1234; e = 1'b1;
    repeat (3) adv();
    #2 check("hlt_t3", {halted, ctrl}, {1'b0, 20'h0});
    adv();
    for (int c = 0; c < 10; c++) begin
      #2 check("halted_quiet", {halted, bus_sel, alu_opsel, ctrl, sc_out}, {1'b1, 29'd0});
      adv();
    end
    start = 1'b1;
    adv();
    start = 1'b0;
    #2 check("restart_t0", {halted, sc_out, bus_sel, ctrl}, {1'b0, 3'd0, 3'd1, 20'h00001});
`ifdef CTRL_SEQ_ICOUNT_EN
    check("icount_hlt", icount, 16'd1);
`endif

    // BSA never loads AC.
    do_reset();
    ir = 16'h5123;
    for (int c = 0; c < 4; c++) begin
      #2 check("bsa_no_ldac", ctrl[C_LD_AC], 1'b0);
      adv();
    end
    #2 check("bsa_t4", {bus_sel, ctrl}, {3'd1, 20'h10002});
    adv();
    #2 check("bsa_t5", {bus_sel, ctrl}, {3'd0, 20'h00008});
    adv();
    #2 check("bsa_done", {sc_out, ctrl[C_LD_AC]}, {3'd0, 1'b0});

    // Random instruction stream against the model.
    do_reset();
    exp_icount = 0;
    for (int n = 0; n < 300; n++) begin
      iv  = gen_ir();
      len = instr_len(iv);
      for (int t = 0; t < len; t++) begin
        ir = iv; ac = pick16(); dr = pick16(); e = 1'($urandom);
        start = ($urandom % 6 == 0);
        exp_obs = micro(t, iv, ac, dr, e);
        exp_valid = 1'b1;
        adv();
      end
      exp_icount++;
      if (iv[15:12] == 4'h7 && iv[0]) begin
        k = $urandom_range(1, 4);
        for (int h = 0; h <= k; h++) begin
          start = (h == k);
          ac = pick16(); dr = pick16(); ir = gen_ir();
          exp_obs = '0;
          exp_obs.halted = 1'b1;
          adv();
        end
        start = 1'b0;
      end
    end
    exp_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
